// File: rtl/cpu_pcstack.sv
// rtl/cpu_pcstack.sv - 8008-style rotating PC stack; CPU_PCSTACK_ERR_EN adds depth tracking and OVF/UNF flags
module cpu_pcstack (
    input  logic        CLK1_I,
    input  logic        nRST_I,
    input  logic        CMD_VLD_I,
    input  logic [2:0]  CMD_I,
    input  logic        COND_I,
    input  logic [7:0]  DATA_I,
    input  logic        SEL_H_I,
    input  logic [1:0]  CYCLE_I,
    output logic [13:0] PC_O,
    output logic [7:0]  DATA_O,
    output logic [2:0]  DEPTH_O,
    output logic        OVF_O,
    output logic        UNF_O
);
    localparam logic [2:0] CMD_INC = 3'b001;
    localparam logic [2:0] CMD_LDL = 3'b010;
    localparam logic [2:0] CMD_LDH = 3'b011;
    localparam logic [2:0] CMD_JMP = 3'b100;
    localparam logic [2:0] CMD_CAL = 3'b101;
    localparam logic [2:0] CMD_RET = 3'b110;
    localparam logic [2:0] CMD_RST = 3'b111;

    logic [13:0] stack_q [8];
    logic [13:0] stack_d [8];
    logic [2:0]  ndx_q, ndx_d;
    logic [13:0] tmp_q, tmp_d;
    logic        push, pop;
    logic [13:0] push_pc;

    always_comb begin
        stack_d = stack_q;
        ndx_d   = ndx_q;
        tmp_d   = tmp_q;
        push    = 1'b0;
        pop     = 1'b0;
        push_pc = tmp_q;
        if (CMD_VLD_I) begin
            case (CMD_I)
                CMD_INC: stack_d[ndx_q] = stack_q[ndx_q] + 14'd1;
                CMD_LDL: tmp_d[7:0] = DATA_I;
                CMD_LDH: tmp_d[13:8] = DATA_I[5:0];
                CMD_JMP: if (COND_I) stack_d[ndx_q] = tmp_q;
                CMD_CAL: push = COND_I;
                CMD_RET: pop = COND_I;
                CMD_RST: begin
                    push    = 1'b1;
                    push_pc = {8'b0, DATA_I[5:3], 3'b000};
                end
                default: ;
            endcase
        end
        // The caller's entry keeps the return address; the new top becomes the live PC.
        if (push) begin
            ndx_d          = ndx_q + 3'd1;
            stack_d[ndx_d] = push_pc;
        end
        if (pop) begin
            ndx_d = ndx_q - 3'd1;
        end
    end

    always_ff @(posedge CLK1_I or negedge nRST_I) begin
        if (!nRST_I) begin
            for (int i = 0; i < 8; i++) begin
                stack_q[i] <= 14'd0;
            end
            ndx_q <= 3'd0;
            tmp_q <= 14'd0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                stack_q[i] <= stack_d[i];
            end
            ndx_q <= ndx_d;
            tmp_q <= tmp_d;
        end
    end

`ifdef CPU_PCSTACK_ERR_EN
    logic [2:0] depth_q, depth_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;

    // Depth saturates at 0..7; wrapping past either end is only recorded by a sticky flag.
    always_comb begin
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (push) begin
            if (depth_q != 3'd7) depth_d = depth_q + 3'd1;
            else                 ovf_d   = 1'b1;
        end
        if (pop) begin
            if (depth_q != 3'd0) depth_d = depth_q - 3'd1;
            else                 unf_d   = 1'b1;
        end
    end

    always_ff @(posedge CLK1_I or negedge nRST_I) begin
        if (!nRST_I) begin
            depth_q <= 3'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign DEPTH_O = depth_q;
    assign OVF_O   = ovf_q;
    assign UNF_O   = unf_q;
`else
    assign DEPTH_O = 3'd0;
    assign OVF_O   = 1'b0;
    assign UNF_O   = 1'b0;
`endif

    assign PC_O   = stack_q[ndx_q];
    assign DATA_O = SEL_H_I ? {CYCLE_I, PC_O[13:8]} : PC_O[7:0];

endmodule

// File: tb/tb_cpu_pcstack.sv
// tb/tb_cpu_pcstack.sv - self-checking bench for cpu_pcstack (vector table, corner sequences, random vs model)
module tb_cpu_pcstack;
`ifdef CPU_PCSTACK_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif
    localparam logic [2:0] NOP = 3'd0, INC = 3'd1, LDL = 3'd2, LDH = 3'd3;
    localparam logic [2:0] JMP = 3'd4, CAL = 3'd5, RET = 3'd6, RST = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic [2:0]  cmd = 3'd0;
    logic        cond = 1'b0;
    logic [7:0]  data = 8'd0;
    logic        sel = 1'b0;
    logic [1:0]  cyc = 2'd0;
    logic [13:0] pc;
    logic [7:0]  data_o;
    logic [2:0]  depth;
    logic        ovf, unf;

    int total = 0;
    int bad = 0;

    // Reference model: eight-slot ring of return addresses, live PC at the pointer.
    int m_stk[8];
    int m_ndx, m_tmp, m_depth;
    bit m_ovf, m_unf;

    typedef struct {
        logic       v;
        logic [2:0] c;
        logic       cd;
        logic [7:0] d;
        int         pc;
        int         depth;
    } vec_t;
    vec_t vecs[$];

    cpu_pcstack dut (
        .CLK1_I(clk), .nRST_I(rst_n), .CMD_VLD_I(vld), .CMD_I(cmd), .COND_I(cond),
        .DATA_I(data), .SEL_H_I(sel), .CYCLE_I(cyc), .PC_O(pc), .DATA_O(data_o),
        .DEPTH_O(depth), .OVF_O(ovf), .UNF_O(unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_stk[i] = 0;
        m_ndx = 0; m_tmp = 0; m_depth = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic model_push(input int target);
        m_ndx = (m_ndx + 1) % 8;
        m_stk[m_ndx] = target;
        if (m_depth < 7) m_depth++; else m_ovf = 1;
    endtask

    task automatic model_apply(input logic v, input logic [2:0] c, input logic cd, input logic [7:0] d);
        int di;
        di = int'(d);
        if (!v) return;
        case (c)
            INC: m_stk[m_ndx] = (m_stk[m_ndx] + 1) % 16384;
            LDL: m_tmp = (m_tmp / 256) * 256 + di;
            LDH: m_tmp = (m_tmp % 256) + (di % 64) * 256;
            JMP: if (cd) m_stk[m_ndx] = m_tmp;
            CAL: if (cd) model_push(m_tmp);
            RET: if (cd) begin
                m_ndx = (m_ndx + 7) % 8;
                if (m_depth > 0) m_depth--; else m_unf = 1;
            end
            RST: model_push(((di / 8) % 8) * 8);
            default: ;
        endcase
    endtask

    task automatic check_outputs();
        int epc;
        epc = m_stk[m_ndx];
        check("pc", 32'(pc), 32'(epc));
        check("depth", 32'(depth), ERR ? 32'(m_depth) : 32'd0);
        check("ovf", 32'(ovf), ERR ? 32'(m_ovf) : 32'd0);
        check("unf", 32'(unf), ERR ? 32'(m_unf) : 32'd0);
        check("data_o", 32'(data_o), sel ? 32'(int'(cyc) * 64 + epc / 256) : 32'(epc % 256));
    endtask

    task automatic step(input logic v, input logic [2:0] c, input logic cd, input logic [7:0] d);
        @(negedge clk);
        vld = v; cmd = c; cond = cd; data = d;
        sel = 1'($urandom); cyc = 2'($urandom);
        @(posedge clk);
        model_apply(v, c, cd, d);
        #1;
        check_outputs();
        vld = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic add(input logic v, input logic [2:0] c, input logic cd, input logic [7:0] d,
                       input int epc, input int edep);
        vec_t x;
        x.v = v; x.c = c; x.cd = cd; x.d = d; x.pc = epc; x.depth = edep;
        vecs.push_back(x);
    endtask

    initial begin
        model_reset();
        // wrap, call/return, conditional and restart scenarios with hand-computed results
        add(1, LDL, 0, 8'hFF, 14'h0000, 0);
        add(1, LDH, 0, 8'hFF, 14'h0000, 0);
        add(1, JMP, 1, 8'h00, 14'h3FFF, 0);
        add(1, INC, 0, 8'h00, 14'h0000, 0);
        add(1, LDL, 0, 8'h00, 14'h0000, 0);
        add(1, LDH, 0, 8'h01, 14'h0000, 0);
        add(1, JMP, 1, 8'h00, 14'h0100, 0);
        add(1, LDL, 0, 8'h34, 14'h0100, 0);
        add(1, LDH, 0, 8'h12, 14'h0100, 0);
        add(1, CAL, 1, 8'h00, 14'h1234, 1);
        add(1, RET, 1, 8'h00, 14'h0100, 0);
        add(1, CAL, 0, 8'h00, 14'h0100, 0);
        add(1, RET, 0, 8'h00, 14'h0100, 0);
        add(1, JMP, 0, 8'h00, 14'h0100, 0);
        add(0, INC, 1, 8'h00, 14'h0100, 0);
        add(1, NOP, 1, 8'hAA, 14'h0100, 0);
        add(1, RST, 0, 8'h3D, 14'h0038, 1);

        rst_n = 1'b0;
        sel = 1'b0; cyc = 2'b11;
        #3;
        check("reset_pc", 32'(pc), 32'h0);
        check("reset_data_lo", 32'(data_o), 32'h00);
        sel = 1'b1;
        #1;
        check("reset_data_hi", 32'(data_o), 32'hC0);
        check("reset_depth", 32'(depth), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].c, vecs[i].cd, vecs[i].d);
            check($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].pc));
            check($sformatf("vec%0d_depth", i), 32'(depth), ERR ? 32'(vecs[i].depth) : 32'd0);
        end
        sel = 1'b1; cyc = 2'b10;
        #1;
        check("restart_data_hi", 32'(data_o), 32'h80);

        // stack limits: eight restarts then eight returns
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, RST, 0, 8'(i * 8));
            check($sformatf("rst%0d_ovf", i), 32'(ovf), (ERR && i == 7) ? 32'd1 : 32'd0);
            check($sformatf("rst%0d_pc", i), 32'(pc), 32'(i * 8));
        end
        check("full_depth", 32'(depth), ERR ? 32'd7 : 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(1, RET, 1, 8'h00);
            check($sformatf("ret%0d_unf", i), 32'(unf), (ERR && i == 7) ? 32'd1 : 32'd0);
        end
        check("empty_depth", 32'(depth), 32'd0);
        check("ovf_sticky", 32'(ovf), ERR ? 32'd1 : 32'd0);
        check("ret8_pc", 32'(pc), 32'd56);

        // asynchronous reset between edges after a call
        do_reset();
        step(1, LDL, 0, 8'h20);
        step(1, CAL, 1, 8'h00);
        check("pre_async_pc", 32'(pc), 32'h20);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_pc", 32'(pc), 32'h0);
        check("async_depth", 32'(depth), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset between LDL and LDH discards the partial operand
        step(1, LDL, 0, 8'h55);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        step(1, LDH, 0, 8'h02);
        step(1, JMP, 1, 8'h00);
        check("partial_tmp_pc", 32'(pc), 32'h0200);

        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            step(($urandom_range(0, 9) != 0), 3'($urandom), 1'($urandom), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_pcstack.md
CPU_PCSTACK -- requirements
Module: cpu_pcstack

Interface
REQ-001 The block SHALL have port CLK1_I, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port nRST_I, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port CMD_VLD_I, input, 1 bit: command strobe, sampled on the CLK1_I rising edge.
REQ-004 The block SHALL have port CMD_I, input, 3 bits: 000 NOP, 001 INC, 010 LDL, 011 LDH, 100 JMP, 101 CAL, 110 RET, 111 RST.
REQ-005 The block SHALL have port COND_I, input, 1 bit: condition qualifier for JMP/CAL/RET; 0 turns the command into NOP.
REQ-006 The block SHALL have port DATA_I, input, 8 bits: operand byte for LDL, LDH and RST.
REQ-007 The block SHALL have port SEL_H_I, input, 1 bit: selects the byte driven on DATA_O; 0 = low address byte, 1 = high address byte.
REQ-008 The block SHALL have port CYCLE_I, input, 2 bits: cycle type (00 PCI, 01 PCC, 10 PCR, 11 PCW), inserted into the high address byte.
REQ-009 The block SHALL have port PC_O, output, 14 bits: current program counter.
REQ-010 The block SHALL have port DATA_O, output, 8 bits: address byte for the bus.
REQ-011 The block SHALL have port DEPTH_O, output, 3 bits: number of outstanding CAL/RST levels, 0..7.
REQ-012 The block SHALL have port OVF_O, output, 1 bit: sticky stack overflow flag.
REQ-013 The block SHALL have port UNF_O, output, 1 bit: sticky stack underflow flag.

Function
REQ-014 Storage SHALL be 8 entries x 14 bits plus a 3-bit pointer NDX, with PC_O = entry[NDX] (8008 rotating stack; one entry is the live PC).
REQ-015 A command SHALL be executed only when CMD_VLD_I=1; its effect SHALL be visible on outputs one CLK1_I edge after the sampling edge, and one command SHALL complete per clock with no busy state.
REQ-016 INC SHALL set entry[NDX] to (entry[NDX]+1) mod 2^14, so 0x3FFF wraps to 0x0000.
REQ-017 LDL SHALL set TMP[7:0]=DATA_I; LDH SHALL set TMP[13:8]=DATA_I[5:0] (DATA_I[7:6] ignored); TMP SHALL be internal only.
REQ-018 JMP with COND_I=1 SHALL set entry[NDX]=TMP.
REQ-019 CAL with COND_I=1 SHALL set NDX=NDX+1 mod 8 and entry[new NDX]=TMP, leaving the old entry, which holds the return address, untouched.
REQ-020 RST SHALL behave as an unconditional CAL with target {8'b0, DATA_I[5:3], 3'b000}, ignoring COND_I.
REQ-021 RET with COND_I=1 SHALL set NDX=NDX-1 mod 8.
REQ-022 Per 8008 convention, the caller SHALL issue INC past operands before CAL, so the pushed entry already addresses the next instruction; the block SHALL NOT auto-increment.
REQ-023 DEPTH_O SHALL increment on an executed CAL/RST when below 7, decrement on an executed RET when above 0, and otherwise hold.
REQ-024 An executed CAL/RST at DEPTH_O=7 SHALL still rotate NDX (oldest entry overwritten) and SHALL set OVF_O.
REQ-025 An executed RET at DEPTH_O=0 SHALL still rotate NDX and SHALL set UNF_O.
REQ-026 OVF_O and UNF_O SHALL stay set until reset.
REQ-027 DATA_O SHALL be combinational: SEL_H_I=0 gives PC_O[7:0]; SEL_H_I=1 gives {CYCLE_I, PC_O[13:8]}.
REQ-028 NOP, and JMP/CAL/RET with COND_I=0, SHALL change no state.

Reset
REQ-029 nRST_I low SHALL immediately clear all 8 entries, NDX, TMP, DEPTH_O, OVF_O and UNF_O to 0, independent of CLK1_I.
REQ-030 After reset, PC_O SHALL be 0x0000 and DATA_O SHALL be 0x00 for SEL_H_I=0, or {CYCLE_I, 6'b0} for SEL_H_I=1.
REQ-031 Reset asserted mid-sequence (e.g. between LDL and LDH) SHALL discard the partial TMP, and the first command after release SHALL see the reset state.

Configuration
REQ-032 With macro CPU_PCSTACK_ERR_EN defined, DEPTH_O tracking, OVF_O and UNF_O SHALL behave per REQ-023..REQ-026.
REQ-033 Without CPU_PCSTACK_ERR_EN, OVF_O and UNF_O SHALL be tied 0, and the depth counter and flag logic SHALL be absent.
REQ-034 Without CPU_PCSTACK_ERR_EN, DEPTH_O SHALL be tied 0, while NDX rotation is unchanged.

Verification
REQ-035 Wrap test: LDL 0xFF, LDH 0x3F, JMP (COND_I=1), INC -> PC_O=0x3FFF after JMP, 0x0000 after INC.
REQ-036 Call/return test: PC=0x0100, LDL 0x34, LDH 0x12, CAL, then RET -> PC_O=0x1234 with DEPTH_O=1, then PC_O=0x0100 with DEPTH_O=0.
REQ-037 Conditional test: CAL and RET with COND_I=0 -> PC_O, DEPTH_O and NDX unchanged; JMP with COND_I=0 -> PC_O unchanged.
REQ-038 Restart test: RST with DATA_I=0x3D -> PC_O=0x0038, DEPTH_O=1; SEL_H_I=1 with CYCLE_I=10 -> DATA_O=0x80.
REQ-039 Stack limit test: 8 RSTs from reset -> OVF_O=1 on the 8th, DEPTH_O=7; 8 RETs -> UNF_O=1 on the 8th, DEPTH_O=0 (ERR_EN build), and both flags 0 throughout in the non-ERR_EN build.
REQ-040 Async reset test: assert nRST_I between clock edges after CAL -> PC_O=0x0000 and DEPTH_O=0 before the next CLK1_I edge.
